// File: rtl/pipe_ctrl.sv
// Five-stage pipeline sequencer: stage valids, allowin/ready-go chain, interlocks, squash.
// Latency: handshake outputs are combinational; valids, fetch_cancel and stall_cnt update on the next clk edge.
// Backpressure: a stage holds its instruction while it is not ready-go or the next stage refuses it.
module pipe_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_ready_go,
   input  logic        id_use_rj,
   input  logic        id_use_rk,
   input  logic [4:0]  id_rj_addr,
   input  logic [4:0]  id_rk_addr,
   input  logic        id_res_from_csr,
   input  logic        id_br_taken,
   input  logic [4:0]  ex_rd,
   input  logic [4:0]  mem_rd,
   input  logic        ex_rf_we,
   input  logic        mem_rf_we,
   input  logic        ex_res_from_dram,
   input  logic        ex_res_from_csr,
   input  logic        mem_res_from_csr,
   input  logic        ex_csr_we,
   input  logic        mem_csr_we,
   input  logic        wb_csr_we,
   input  logic        ex_busy,
   input  logic        wb_ex,
   input  logic        wb_is_ertn,
   output logic        if_valid,
   output logic        id_valid,
   output logic        ex_valid,
   output logic        mem_valid,
   output logic        wb_valid,
   output logic        id_allowin,
   output logic        ex_allowin,
   output logic        mem_allowin,
   output logic        id_ready_go,
   output logic        ex_ready_go,
   output logic        pipe_flush,
   output logic        br_cancel,
   output logic        fetch_cancel,
   output logic [31:0] stall_cnt
);

   logic if_go;
   logic if_allowin;
   logic rj_ex_hit;
   logic rk_ex_hit;
   logic rj_mem_hit;
   logic rk_mem_hit;
   logic ex_late_result;
   logic mem_late_result;
   logic load_use;
   logic mem_csr_use;
   logic csr_wr_pending;
   logic hazard;
   logic fc_set;

   // Source-register comparisons; r0 is hardwired zero and never matches.
   assign rj_ex_hit  = id_use_rj && (id_rj_addr != 5'd0) && (id_rj_addr == ex_rd);
   assign rk_ex_hit  = id_use_rk && (id_rk_addr != 5'd0) && (id_rk_addr == ex_rd);
   assign rj_mem_hit = id_use_rj && (id_rj_addr != 5'd0) && (id_rj_addr == mem_rd);
   assign rk_mem_hit = id_use_rk && (id_rk_addr != 5'd0) && (id_rk_addr == mem_rd);

   // Results that are not yet available for forwarding: load or CSR read in EX, CSR read in MEM.
   assign ex_late_result  = ex_valid & ex_rf_we & (ex_res_from_dram | ex_res_from_csr);
   assign mem_late_result = mem_valid & mem_rf_we & mem_res_from_csr;

   assign load_use       = ex_late_result & (rj_ex_hit | rk_ex_hit);
   assign mem_csr_use    = mem_late_result & (rj_mem_hit | rk_mem_hit);
   assign csr_wr_pending = id_res_from_csr &
                           ((ex_valid & ex_csr_we) | (mem_valid & mem_csr_we) | (wb_valid & wb_csr_we));
   assign hazard         = id_valid & (load_use | mem_csr_use | csr_wr_pending);

   // Handshake chain, built back-to-front from WB (which always accepts).
   assign pipe_flush  = wb_valid & (wb_ex | wb_is_ertn);
   assign if_go       = if_ready_go & ~fetch_cancel;
   assign id_ready_go = ~hazard;
   assign ex_ready_go = ~ex_busy;
   assign mem_allowin = 1'b1;
   assign ex_allowin  = ~ex_valid | (ex_ready_go & mem_allowin);
   assign id_allowin  = ~id_valid | (id_ready_go & ex_allowin);
   assign if_allowin  = ~if_valid | (if_go & id_allowin);

   // A flush in the same cycle overrides the branch redirect.
   assign br_cancel = id_valid & id_ready_go & ex_allowin & id_br_taken & ~pipe_flush;

   // A redirect while the IF fetch is still outstanding leaves a stale return to discard.
   assign fc_set = (pipe_flush | br_cancel) & if_valid & ~if_ready_go;

   // Stage valid bits; IF refills itself after every reset or flush.
   always_ff @(posedge clk) begin
      if (rst || pipe_flush) begin
         if_valid  <= 1'b0;
         id_valid  <= 1'b0;
         ex_valid  <= 1'b0;
         mem_valid <= 1'b0;
         wb_valid  <= 1'b0;
      end else begin
         if (if_allowin)  if_valid  <= 1'b1;
         if (id_allowin)  id_valid  <= if_valid & if_go & ~br_cancel;
         if (ex_allowin)  ex_valid  <= id_valid & id_ready_go;
         if (mem_allowin) mem_valid <= ex_valid & ex_ready_go;
         wb_valid <= mem_valid;
      end
   end

   // Sticky fetch-cancel: set wins over the clearing return.
   always_ff @(posedge clk) begin
      if (rst)
         fetch_cancel <= 1'b0;
      else if (fc_set)
         fetch_cancel <= 1'b1;
      else if (fetch_cancel && if_ready_go)
         fetch_cancel <= 1'b0;
   end

   // Saturating count of cycles where ID is held by an interlock.
   always_ff @(posedge clk) begin
      if (rst)
         stall_cnt <= 32'd0;
      else if (id_valid && !id_ready_go && (stall_cnt != 32'hFFFF_FFFF))
         stall_cnt <= stall_cnt + 32'd1;
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized and directed bench for pipe_ctrl against a stage-array reference model.
// Latency: outputs sampled 3 time units after each rising edge, before the next edge.
// Backpressure: modelled as allowin propagated from WB back to IF over a valid array.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_ready_go, id_use_rj, id_use_rk, id_res_from_csr, id_br_taken;
   logic [4:0]  id_rj_addr, id_rk_addr, ex_rd, mem_rd;
   logic        ex_rf_we, mem_rf_we, ex_res_from_dram, ex_res_from_csr, mem_res_from_csr;
   logic        ex_csr_we, mem_csr_we, wb_csr_we, ex_busy, wb_ex, wb_is_ertn;
   logic        if_valid, id_valid, ex_valid, mem_valid, wb_valid;
   logic        id_allowin, ex_allowin, mem_allowin, id_ready_go, ex_ready_go;
   logic        pipe_flush, br_cancel, fetch_cancel;
   logic [31:0] stall_cnt;

   int n_chk = 0;
   int n_fail = 0;

   // reference state: stage 0..4 = IF..WB
   logic        mv[5];
   logic        mfc;
   logic [31:0] mcnt;
   logic        e_allow[5], e_rg[5];
   logic        e_hz, e_flush, e_brc;

   pipe_ctrl dut (
      .clk(clk), .rst(rst), .if_ready_go(if_ready_go),
      .id_use_rj(id_use_rj), .id_use_rk(id_use_rk),
      .id_rj_addr(id_rj_addr), .id_rk_addr(id_rk_addr),
      .id_res_from_csr(id_res_from_csr), .id_br_taken(id_br_taken),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we),
      .ex_res_from_dram(ex_res_from_dram), .ex_res_from_csr(ex_res_from_csr),
      .mem_res_from_csr(mem_res_from_csr), .ex_csr_we(ex_csr_we),
      .mem_csr_we(mem_csr_we), .wb_csr_we(wb_csr_we), .ex_busy(ex_busy),
      .wb_ex(wb_ex), .wb_is_ertn(wb_is_ertn),
      .if_valid(if_valid), .id_valid(id_valid), .ex_valid(ex_valid),
      .mem_valid(mem_valid), .wb_valid(wb_valid),
      .id_allowin(id_allowin), .ex_allowin(ex_allowin), .mem_allowin(mem_allowin),
      .id_ready_go(id_ready_go), .ex_ready_go(ex_ready_go),
      .pipe_flush(pipe_flush), .br_cancel(br_cancel),
      .fetch_cancel(fetch_cancel), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic hit(input logic use_r, input logic [4:0] a, input logic [4:0] rd);
      return use_r && (a != 5'd0) && (a == rd);
   endfunction

   // Expected combinational values from the current model state and inputs.
   task automatic model_comb();
      logic ld, mc, cw;
      e_flush = mv[4] && (wb_ex || wb_is_ertn);
      ld = mv[2] && ex_rf_we && (ex_res_from_dram || ex_res_from_csr) &&
           (hit(id_use_rj, id_rj_addr, ex_rd) || hit(id_use_rk, id_rk_addr, ex_rd));
      mc = mv[3] && mem_rf_we && mem_res_from_csr &&
           (hit(id_use_rj, id_rj_addr, mem_rd) || hit(id_use_rk, id_rk_addr, mem_rd));
      cw = id_res_from_csr && ((mv[2] && ex_csr_we) || (mv[3] && mem_csr_we) || (mv[4] && wb_csr_we));
      e_hz = mv[1] && (ld || mc || cw);
      e_rg[0] = if_ready_go && !mfc;
      e_rg[1] = !e_hz;
      e_rg[2] = !ex_busy;
      e_rg[3] = 1'b1;
      e_rg[4] = 1'b1;
      e_allow[4] = 1'b1;
      for (int i = 3; i >= 0; i--) e_allow[i] = !mv[i] || (e_rg[i] && e_allow[i+1]);
      e_brc = mv[1] && e_rg[1] && e_allow[2] && id_br_taken && !e_flush;
   endtask

   // One clock: check everything, advance the model and the clock.
   task automatic step();
      logic nv[5];
      logic nfc;
      logic [31:0] ncnt;
      #2;
      model_comb();
      chk("if_valid", {31'd0, if_valid}, {31'd0, mv[0]});
      chk("id_valid", {31'd0, id_valid}, {31'd0, mv[1]});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, mv[2]});
      chk("mem_valid", {31'd0, mem_valid}, {31'd0, mv[3]});
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, mv[4]});
      chk("id_allowin", {31'd0, id_allowin}, {31'd0, e_allow[1]});
      chk("ex_allowin", {31'd0, ex_allowin}, {31'd0, e_allow[2]});
      chk("mem_allowin", {31'd0, mem_allowin}, {31'd0, e_allow[3]});
      chk("id_ready_go", {31'd0, id_ready_go}, {31'd0, e_rg[1]});
      chk("ex_ready_go", {31'd0, ex_ready_go}, {31'd0, e_rg[2]});
      chk("pipe_flush", {31'd0, pipe_flush}, {31'd0, e_flush});
      chk("br_cancel", {31'd0, br_cancel}, {31'd0, e_brc});
      chk("fetch_cancel", {31'd0, fetch_cancel}, {31'd0, mfc});
      chk("stall_cnt", stall_cnt, mcnt);
      if (rst || e_flush) begin
         for (int i = 0; i < 5; i++) nv[i] = 1'b0;
      end else begin
         nv[0] = e_allow[0] ? 1'b1 : mv[0];
         for (int i = 1; i < 5; i++)
            nv[i] = e_allow[i] ? (mv[i-1] && e_rg[i-1] && !(i == 1 && e_brc)) : mv[i];
      end
      if (rst) nfc = 1'b0;
      else if ((e_flush || e_brc) && mv[0] && !if_ready_go) nfc = 1'b1;
      else if (mfc && if_ready_go) nfc = 1'b0;
      else nfc = mfc;
      if (rst) ncnt = 32'd0;
      else if (mv[1] && !e_rg[1] && mcnt != 32'hFFFF_FFFF) ncnt = mcnt + 32'd1;
      else ncnt = mcnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) mv[i] = nv[i];
      mfc = nfc;
      mcnt = ncnt;
   endtask

   task automatic clr_in();
      rst = 1'b0; if_ready_go = 1'b0; id_use_rj = 1'b0; id_use_rk = 1'b0;
      id_rj_addr = 5'd0; id_rk_addr = 5'd0; id_res_from_csr = 1'b0; id_br_taken = 1'b0;
      ex_rd = 5'd0; mem_rd = 5'd0; ex_rf_we = 1'b0; mem_rf_we = 1'b0;
      ex_res_from_dram = 1'b0; ex_res_from_csr = 1'b0; mem_res_from_csr = 1'b0;
      ex_csr_we = 1'b0; mem_csr_we = 1'b0; wb_csr_we = 1'b0; ex_busy = 1'b0;
      wb_ex = 1'b0; wb_is_ertn = 1'b0;
   endtask

   task automatic fill();
      clr_in();
      if_ready_go = 1'b1;
      for (int i = 0; i < 6; i++) step();
   endtask

   initial begin
      logic [31:0] c0;
      clr_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) mv[i] = 1'b0;
      mfc = 1'b0;
      mcnt = 32'd0;
      step(); step();
      // reset release: IF valid one cycle later, WB valid at cycle 5
      clr_in();
      if_ready_go = 1'b1;
      step();
      chk("rst_if_valid", {31'd0, if_valid}, 32'd1);
      chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
      chk("rst_stall_cnt", stall_cnt, 32'd0);
      for (int i = 0; i < 4; i++) step();
      chk("rst_wb_at_5", {31'd0, wb_valid}, 32'd1);

      // load-use on rj=5: one stall cycle then an EX bubble
      fill();
      c0 = stall_cnt;
      ex_rf_we = 1'b1; ex_res_from_dram = 1'b1; ex_rd = 5'd5;
      id_use_rj = 1'b1; id_rj_addr = 5'd5;
      step();
      chk("lu_ex_bubble", {31'd0, ex_valid}, 32'd0);
      step();
      chk("lu_stall_cnt", stall_cnt - c0, 32'd1);
      // same with r0: no stall
      fill();
      c0 = stall_cnt;
      ex_rf_we = 1'b1; ex_res_from_dram = 1'b1; ex_rd = 5'd0;
      id_use_rj = 1'b1; id_rj_addr = 5'd0;
      step(); step();
      chk("lu_r0_no_stall", stall_cnt - c0, 32'd0);

      // branch while fetch pending: stale return dropped
      fill();
      if_ready_go = 1'b0; id_br_taken = 1'b1;
      #2;
      chk("br_cancel_hi", {31'd0, br_cancel}, 32'd1);
      step();
      chk("br_fc_set", {31'd0, fetch_cancel}, 32'd1);
      id_br_taken = 1'b0; if_ready_go = 1'b1;
      step();
      chk("br_drop_id", {31'd0, id_valid}, 32'd0);
      chk("br_fc_clr", {31'd0, fetch_cancel}, 32'd0);

      // exception flush together with a taken branch
      fill();
      wb_ex = 1'b1; id_br_taken = 1'b1;
      #2;
      chk("fl_flush", {31'd0, pipe_flush}, 32'd1);
      chk("fl_no_brc", {31'd0, br_cancel}, 32'd0);
      step();
      chk("fl_valids", {27'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 32'd0);
      clr_in();

      // divider busy for 4 cycles
      fill();
      c0 = stall_cnt;
      ex_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("div_hold", {30'd0, ex_allowin, id_allowin}, 32'd0);
         step();
         chk("div_mem_bubble", {31'd0, mem_valid}, 32'd0);
      end
      ex_busy = 1'b0;
      chk("div_no_count", stall_cnt - c0, 32'd0);

      // CSR write in flight against a CSR read in ID
      fill();
      c0 = stall_cnt;
      id_res_from_csr = 1'b1; ex_csr_we = 1'b1;
      step();
      ex_csr_we = 1'b0; mem_csr_we = 1'b1;
      step();
      mem_csr_we = 1'b0; wb_csr_we = 1'b1;
      step();
      wb_csr_we = 1'b0;
      step();
      chk("csr_stall_cnt", stall_cnt - c0, 32'd3);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst              = ($urandom % 250) == 0;
         if_ready_go      = ($urandom % 4) != 0;
         id_use_rj        = $urandom % 2;
         id_use_rk        = $urandom % 2;
         id_rj_addr       = 5'($urandom % 4);
         id_rk_addr       = 5'($urandom % 4);
         ex_rd            = 5'($urandom % 4);
         mem_rd           = 5'($urandom % 4);
         id_res_from_csr  = ($urandom % 4) == 0;
         id_br_taken      = ($urandom % 6) == 0;
         ex_rf_we         = $urandom % 2;
         mem_rf_we        = $urandom % 2;
         ex_res_from_dram = ($urandom % 3) == 0;
         ex_res_from_csr  = ($urandom % 5) == 0;
         mem_res_from_csr = ($urandom % 5) == 0;
         ex_csr_we        = ($urandom % 5) == 0;
         mem_csr_we       = ($urandom % 5) == 0;
         wb_csr_we        = ($urandom % 5) == 0;
         ex_busy          = ($urandom % 5) == 0;
         wb_ex            = ($urandom % 25) == 0;
         wb_is_ertn       = ($urandom % 40) == 0;
         step();
      end

      // mid-run reset clears everything regardless of other inputs
      if_ready_go = 1'b1; wb_ex = 1'b1; id_br_taken = 1'b1; rst = 1'b1;
      step();
      chk("mid_rst_valids", {27'd0, if_valid, id_valid, ex_valid, mem_valid, wb_valid}, 32'd0);
      chk("mid_rst_cnt", stall_cnt, 32'd0);
      chk("mid_rst_fc", {31'd0, fetch_cancel}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
